// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antenna_drv_pkg.sv
// Shared definitions for the antenna-net driver.
// Contents: mode encodings, FSM state type, and the maximal-length LFSR
// tap-mask lookup for widths 2..32 (Galois right-shift form, bit t-1 set
// for each polynomial tap t).
package gf180mcu_fd_sc_mcu9t5v0__antenna_drv_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_WALK   = 2'b10;
  localparam logic [1:0] MODE_LFSR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Tap mask for a maximal-length LFSR of the given width.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antenna_drv_pat.sv
// Pattern next-state logic: given the latched mode and current net value,
// produce the net value after one update event (combinational).
// Ports: i_mode (pattern select), i_z (current nets), o_z_next_c (next nets).
// The LFSR pattern is built only when GF180MCU_FD_SC_MCU9T5V0_ANTDRV_LFSR_EN
// is defined; otherwise MODE_LFSR falls through to hold.
module gf180mcu_fd_sc_mcu9t5v0__antenna_drv_pat
  import gf180mcu_fd_sc_mcu9t5v0__antenna_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_z,
  output logic [WIDTH-1:0] o_z_next_c
);

`ifdef GF180MCU_FD_SC_MCU9T5V0_ANTDRV_LFSR_EN
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] w_lfsr_src;
  logic [WIDTH-1:0] w_lfsr_next;

  // All-zero is the LFSR lock-up state, so it is nudged to 1 before shifting.
  assign w_lfsr_src  = (i_z == '0) ? WIDTH'(1) : i_z;
  assign w_lfsr_next = (w_lfsr_src >> 1) ^ (w_lfsr_src[0] ? TAPS : '0);
`endif

  always_comb begin
    o_z_next_c = i_z;
    case (i_mode)
      MODE_TOGGLE: o_z_next_c = ~i_z;
      MODE_WALK:   o_z_next_c = {i_z[WIDTH-2:0], i_z[WIDTH-1]};
`ifdef GF180MCU_FD_SC_MCU9T5V0_ANTDRV_LFSR_EN
      MODE_LFSR:   o_z_next_c = w_lfsr_next;
`endif
      default:     o_z_next_c = i_z;
    endcase
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antenna_drv.sv
// Antenna-net driver top: launches a burst of LEN update events on WIDTH
// nets, one event every DIV+1 clocks, with BUSY/DONE handshake.
// Ports: CLK, RST (async, active-high), START, MODE, DIV, LEN, SEED in;
// Z (nets), BUSY, DONE (one-cycle pulse), EVCNT (events this burst) out.
// All outputs are registered.
// Optional LFSR pattern: GF180MCU_FD_SC_MCU9T5V0_ANTDRV_LFSR_EN.
module gf180mcu_fd_sc_mcu9t5v0__antenna_drv
  import gf180mcu_fd_sc_mcu9t5v0__antenna_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIVW  = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [DIVW-1:0]  DIV,
  input  logic [CNTW-1:0]  LEN,
  input  logic [WIDTH-1:0] SEED,
  output logic [WIDTH-1:0] Z,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNTW-1:0]  EVCNT
);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_mode,  w_mode_nxt;
  logic [DIVW-1:0]  r_div,   w_div_nxt;
  logic [CNTW-1:0]  r_len,   w_len_nxt;
  logic [DIVW-1:0]  r_presc, w_presc_nxt;
  logic [WIDTH-1:0] r_z,     w_z_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic [CNTW-1:0]  r_evcnt, w_evcnt_nxt;

  logic [WIDTH-1:0] w_pat;
  logic [CNTW-1:0]  w_evcnt_inc;

  assign w_evcnt_inc = r_evcnt + CNTW'(1);

  gf180mcu_fd_sc_mcu9t5v0__antenna_drv_pat #(
    .WIDTH (WIDTH)
  ) u_pat (
    .i_mode     (r_mode),
    .i_z        (r_z),
    .o_z_next_c (w_pat)
  );

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_div   <= '0;
      r_len   <= '0;
      r_presc <= '0;
      r_z     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_evcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_div   <= w_div_nxt;
      r_len   <= w_len_nxt;
      r_presc <= w_presc_nxt;
      r_z     <= w_z_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_evcnt <= w_evcnt_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_div_nxt   = r_div;
    w_len_nxt   = r_len;
    w_presc_nxt = r_presc;
    w_z_nxt     = r_z;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_evcnt_nxt = r_evcnt;

    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_mode_nxt  = MODE;
          w_div_nxt   = DIV;
          w_len_nxt   = LEN;
          w_z_nxt     = SEED;
          w_presc_nxt = '0;
          w_evcnt_nxt = '0;
          // A zero-length burst completes at the accepting edge.
          if (LEN == '0) begin
            w_state_nxt = ST_FIN;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (r_presc == r_div) begin
          w_presc_nxt = '0;
          w_evcnt_nxt = w_evcnt_inc;
          w_z_nxt     = w_pat;
          if (w_evcnt_inc == r_len) begin
            w_state_nxt = ST_FIN;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + DIVW'(1);
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign Z     = r_z;
  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign EVCNT = r_evcnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__antenna_drv.sv
// Bench for the antenna-net driver (WIDTH=8, DIVW=8, CNTW=16).
// Table of complete bursts plus directed multi-cycle sequences.
module tb_gf180mcu_fd_sc_mcu9t5v0__antenna_drv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  div;
  logic [15:0] len;
  logic [7:0]  seed;
  logic [7:0]  z;
  logic        busy;
  logic        done;
  logic [15:0] evcnt;

  int n_tests;
  int n_fail;

  gf180mcu_fd_sc_mcu9t5v0__antenna_drv dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .MODE  (mode),
    .DIV   (div),
    .LEN   (len),
    .SEED  (seed),
    .Z     (z),
    .BUSY  (busy),
    .DONE  (done),
    .EVCNT (evcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  div;
    logic [15:0] len;
    logic [7:0]  seed;
    logic [7:0]  exp_z;
    logic [15:0] exp_ev;
    int          exp_cyc;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue START; returns after the accepting edge (t0) with inputs scrambled.
  task automatic launch(input logic [1:0] m, input logic [7:0] d,
                        input logic [15:0] l, input logic [7:0] s);
    mode = m; div = d; len = l; seed = s; start = 1'b1;
    tick();
    start = 1'b0;
    mode = ~m; div = 8'h5; len = 16'h3; seed = ~s;
  endtask

  // Wait for DONE, counting edges since t0; returns -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    launch(v.mode, v.div, v.len, v.seed);
    check($sformatf("v%0d_busy_t0", idx), 32'(busy), (v.len != 0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_seed_t0", idx), 32'(z), 32'(v.seed));
    wait_done(cyc);
    check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.exp_cyc));
    check($sformatf("v%0d_z", idx), 32'(z), 32'(v.exp_z));
    check($sformatf("v%0d_evcnt", idx), 32'(evcnt), 32'(v.exp_ev));
    check($sformatf("v%0d_busy_fin", idx), 32'(busy), 32'd0);
    tick();
    check($sformatf("v%0d_done_fall", idx), 32'(done), 32'd0);
    check($sformatf("v%0d_z_hold", idx), 32'(z), 32'(v.exp_z));
  endtask

  initial begin
    vec_t vecs[9];
    logic [7:0] walk_exp[9];
    bit   seen[256];
    int   cyc;
    int   uniq;
    int   zero_hits;
    int   bad;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{2'b01, 8'd2,   16'd3, 8'h5A, 8'hA5, 16'd3, 9};
    vecs[1] = '{2'b10, 8'd0,   16'd9, 8'h01, 8'h02, 16'd9, 9};
    vecs[2] = '{2'b00, 8'd4,   16'd5, 8'hC3, 8'hC3, 16'd5, 25};
    vecs[3] = '{2'b01, 8'd0,   16'd4, 8'h0F, 8'h0F, 16'd4, 4};
    vecs[4] = '{2'b10, 8'd1,   16'd3, 8'h81, 8'h0C, 16'd3, 6};
    vecs[5] = '{2'b01, 8'd7,   16'd0, 8'h77, 8'h77, 16'd0, 0};
    vecs[6] = '{2'b10, 8'd255, 16'd2, 8'h40, 8'h01, 16'd2, 512};
    vecs[7] = '{2'b01, 8'd3,   16'd1, 8'hFF, 8'h00, 16'd1, 4};
`ifdef GF180MCU_FD_SC_MCU9T5V0_ANTDRV_LFSR_EN
    vecs[8] = '{2'b11, 8'd1,   16'd3, 8'h3C, 8'hBF, 16'd3, 6};
`else
    vecs[8] = '{2'b11, 8'd1,   16'd3, 8'h3C, 8'h3C, 16'd3, 6};
`endif

    walk_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

    rst = 1'b1; start = 1'b0; mode = 2'b00; div = '0; len = '0; seed = '0;
    #2;
    check("rst_z", 32'(z), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_evcnt", 32'(evcnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Walk pattern edge by edge.
    launch(2'b10, 8'd0, 16'd9, 8'h01);
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("walk_step%0d", k + 1), 32'(z), 32'(walk_exp[k]));
      check($sformatf("walk_ev%0d", k + 1), 32'(evcnt), 32'(k + 1));
    end
    check("walk_done", 32'(done), 32'd1);
    tick();

    // Toggle timing: no change between events.
    launch(2'b01, 8'd2, 16'd3, 8'h5A);
    tick(); tick();
    check("tog_t2", 32'(z), 32'h5A);
    tick();
    check("tog_t3", 32'(z), 32'hA5);
    tick(); tick(); tick();
    check("tog_t6", 32'(z), 32'h5A);
    check("tog_done_t6", 32'(done), 32'd0);
    tick(); tick(); tick();
    check("tog_t9", 32'(z), 32'hA5);
    check("tog_done_t9", 32'(done), 32'd1);
    tick();

    // Reset in the middle of a burst, then a complete rerun.
    launch(2'b01, 8'd3, 16'd10, 8'h5A);
    for (int k = 0; k < 16; k++) tick();
    check("rstmid_ev4", 32'(evcnt), 32'd4);
    check("rstmid_busy", 32'(busy), 32'd1);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rstmid_z", 32'(z), 32'd0);
    check("rstmid_busy0", 32'(busy), 32'd0);
    check("rstmid_evcnt", 32'(evcnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    launch(2'b01, 8'd3, 16'd10, 8'h5A);
    wait_done(cyc);
    check("rerun_cycles", 32'(cyc), 32'd40);
    check("rerun_evcnt", 32'(evcnt), 32'd10);
    check("rerun_z", 32'(z), 32'h5A);
    tick();

    // START pulsed during a burst is ignored.
    launch(2'b00, 8'd1, 16'd6, 8'h11);
    for (int k = 0; k < 5; k++) tick();
    seed = 8'hEE; len = 16'd1; mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    check("midstart_ev", 32'(evcnt), 32'd3);
    check("midstart_z", 32'(z), 32'h11);
    check("midstart_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    check("midstart_cycles", 32'(cyc + 6), 32'd12);
    check("midstart_evfin", 32'(evcnt), 32'd6);
    tick();

    // LEN=0: BUSY never asserted across the pulse.
    launch(2'b10, 8'd0, 16'd0, 8'h33);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_busy2", 32'(busy), 32'd0);
    check("len0_z", 32'(z), 32'h33);

    // Long LFSR run from a zero seed.
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    uniq = 0; zero_hits = 0; bad = 0;
    launch(2'b11, 8'd0, 16'd255, 8'h00);
    for (int k = 0; k < 255; k++) begin
      tick();
`ifdef GF180MCU_FD_SC_MCU9T5V0_ANTDRV_LFSR_EN
      if (z == 8'h00) zero_hits++;
      else if (!seen[z]) begin
        seen[z] = 1'b1;
        uniq++;
      end
`else
      if (z != 8'h00) bad++;
`endif
    end
`ifdef GF180MCU_FD_SC_MCU9T5V0_ANTDRV_LFSR_EN
    check("lfsr_zero_hits", 32'(zero_hits), 32'd0);
    check("lfsr_unique", 32'(uniq), 32'd255);
`else
    check("lfsr_off_hold", 32'(bad), 32'd0);
`endif
    check("lfsr_done", 32'(done), 32'd1);
    check("lfsr_evcnt", 32'(evcnt), 32'd255);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
